// File: rtl/ps2_char_ctrl_if.sv
// Scan-byte input and key/event outputs of the PS/2 character controller.
// master drives scan bytes and observes outputs; slave is the controller.
interface ps2_char_ctrl_if;
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic [1:0] char;
    logic       active;
    logic [3:0] key_down;
    logic       event_valid;
    logic [1:0] event_char;
    logic       event_make;
    logic       err;

    modport master (
        output scan_byte, scan_valid,
        input  char, active, key_down, event_valid, event_char, event_make, err
    );

    modport slave (
        input  scan_byte, scan_valid,
        output char, active, key_down, event_valid, event_char, event_make, err
    );
endinterface

// File: rtl/ps2_char_ctrl.sv
// PS/2 scan-code parser tracking four character keys (make/break/extended prefixes).
// Define TYPEMATIC_EN to report repeated make codes of already-held keys.
module ps2_char_ctrl #(
    parameter int unsigned TIMEOUT = 25000
) (
    input logic            clk25,
    input logic            reset,
    ps2_char_ctrl_if.slave bus
);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout;
    logic        is_key;
    logic [1:0]  key_idx;
    logic        do_make, do_break, make_ok;
    logic [3:0]  remaining;

    logic [1:0]  char_q, char_d;
    logic        active_q;
    logic [3:0]  key_down_q, key_down_d;
    logic        event_valid_q, event_valid_d;
    logic [1:0]  event_char_q, event_char_d;
    logic        event_make_q, event_make_d;
    logic        err_q, err_d;

    always_comb begin
        is_key  = 1'b1;
        key_idx = 2'd0;
        case (bus.scan_byte)
            8'h16:   key_idx = 2'd0;
            8'h1E:   key_idx = 2'd1;
            8'h26:   key_idx = 2'd2;
            8'h25:   key_idx = 2'd3;
            default: is_key  = 1'b0;
        endcase
    end

    assign timeout = (state_q != StIdle) && (cnt_q == TimeoutLast);

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A byte arriving in the timeout cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.scan_valid) begin
            cnt_d = 16'd0;
            case (state_q)
                StIdle: begin
                    if (bus.scan_byte == 8'hF0)      state_d = StBreak;
                    else if (bus.scan_byte == 8'hE0) state_d = StExt;
                end
                StBreak: begin
                    if (bus.scan_byte == 8'hE0)      state_d = StExt;
                    else if (bus.scan_byte != 8'hF0) state_d = StIdle;
                end
                StExt: begin
                    if (bus.scan_byte == 8'hF0)      state_d = StExtBreak;
                    else if (bus.scan_byte != 8'hE0) state_d = StIdle;
                end
                StExtBreak: begin
                    if (bus.scan_byte == 8'hE0)      state_d = StExt;
                    else if (bus.scan_byte != 8'hF0) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q == StIdle) begin
            cnt_d = 16'd0;
        end else if (timeout) begin
            state_d = StIdle;
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign do_make   = bus.scan_valid && (state_q == StIdle) && is_key;
    assign do_break  = bus.scan_valid && (state_q == StBreak) && is_key;
    assign remaining = key_down_q & ~(4'b0001 << key_idx);

`ifdef TYPEMATIC_EN
    assign make_ok = 1'b1;
`else
    assign make_ok = !key_down_q[key_idx];
`endif

    always_comb begin
        key_down_d    = key_down_q;
        char_d        = char_q;
        event_valid_d = 1'b0;
        event_char_d  = event_char_q;
        event_make_d  = event_make_q;
        err_d         = timeout && !bus.scan_valid;
        if (do_make && make_ok) begin
            key_down_d[key_idx] = 1'b1;
            char_d              = key_idx;
            event_valid_d       = 1'b1;
            event_char_d        = key_idx;
            event_make_d        = 1'b1;
        end else if (do_break && key_down_q[key_idx]) begin
            key_down_d    = remaining;
            event_valid_d = 1'b1;
            event_char_d  = key_idx;
            event_make_d  = 1'b0;
            // Releasing the shown key falls back to the lowest held key, if any.
            if (key_idx == char_q && remaining != 4'b0000) begin
                if (remaining[0])      char_d = 2'd0;
                else if (remaining[1]) char_d = 2'd1;
                else if (remaining[2]) char_d = 2'd2;
                else                   char_d = 2'd3;
            end
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            char_q        <= 2'd0;
            active_q      <= 1'b0;
            key_down_q    <= 4'd0;
            event_valid_q <= 1'b0;
            event_char_q  <= 2'd0;
            event_make_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            char_q        <= char_d;
            active_q      <= |key_down_d;
            key_down_q    <= key_down_d;
            event_valid_q <= event_valid_d;
            event_char_q  <= event_char_d;
            event_make_q  <= event_make_d;
            err_q         <= err_d;
        end
    end

    assign bus.char        = char_q;
    assign bus.active      = active_q;
    assign bus.key_down    = key_down_q;
    assign bus.event_valid = event_valid_q;
    assign bus.event_char  = event_char_q;
    assign bus.event_make  = event_make_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_char_ctrl.sv
// Directed bench for ps2_char_ctrl: key tracking, prefixes, timeout, typematic and reset.
module tb_ps2_char_ctrl;
    logic clk25 = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic seen;

    ps2_char_ctrl_if bus ();

    ps2_char_ctrl dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs updated.
    task automatic send(input logic [7:0] b);
        bus.scan_byte  = b;
        bus.scan_valid = 1'b1;
        @(negedge clk25);
        bus.scan_valid = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] kd, input logic [1:0] ch,
                             input logic ev);
        chk({tag, ".kd"}, 32'(bus.key_down), 32'(kd));
        chk({tag, ".char"}, 32'(bus.char), 32'(ch));
        chk({tag, ".active"}, 32'(bus.active), 32'(|kd));
        chk({tag, ".ev"}, 32'(bus.event_valid), 32'(ev));
    endtask

    task automatic chk_event(input string tag, input logic [1:0] ch, input logic mk);
        chk({tag, ".evchar"}, 32'(bus.event_char), 32'(ch));
        chk({tag, ".evmake"}, 32'(bus.event_make), 32'(mk));
    endtask

    initial begin
        bus.scan_byte  = 8'h00;
        bus.scan_valid = 1'b0;
        repeat (3) @(negedge clk25);
        reset = 1'b0;
        @(negedge clk25);
        chk_state("reset", 4'b0000, 2'd0, 1'b0);
        chk_event("reset", 2'd0, 1'b0);
        chk("reset.err", 32'(bus.err), 32'h0);

        send(8'h1E);
        chk_state("make1E", 4'b0010, 2'd1, 1'b1);
        chk_event("make1E", 2'd1, 1'b1);
        @(negedge clk25);
        chk("make1E.pulse", 32'(bus.event_valid), 32'h0);
        send(8'hF0);
        chk("brk1E.prefix", 32'(bus.event_valid), 32'h0);
        send(8'h1E);
        chk_state("brk1E", 4'b0000, 2'd1, 1'b1);
        chk_event("brk1E", 2'd1, 1'b0);

        send(8'h16);
        chk_state("make16", 4'b0001, 2'd0, 1'b1);
        send(8'h26);
        chk_state("make26", 4'b0101, 2'd2, 1'b1);
        send(8'hF0);
        chk("brk26.prefix", 32'(bus.event_valid), 32'h0);
        send(8'h26);
        chk_state("brk26", 4'b0001, 2'd0, 1'b1);
        chk_event("brk26", 2'd2, 1'b0);

        send(8'hE0);
        chk("ext.e0", 32'(bus.event_valid), 32'h0);
        send(8'hF0);
        chk("ext.f0", 32'(bus.event_valid), 32'h0);
        send(8'h16);
        chk_state("ext.16", 4'b0001, 2'd0, 1'b0);
        send(8'h25);
        chk_state("make25", 4'b1001, 2'd3, 1'b1);
        chk_event("make25", 2'd3, 1'b1);

        send(8'hF0);
        send(8'h1E);
        chk_state("brk_unheld", 4'b1001, 2'd3, 1'b0);
        send(8'hF0);
        send(8'h25);
        chk_state("brk25", 4'b0001, 2'd0, 1'b1);
        chk_event("brk25", 2'd3, 1'b0);

        // Prefix timeout: counter reaches TIMEOUT-1 after 24999 edges, err follows.
        send(8'hF0);
        seen = 1'b0;
        for (int i = 0; i < 24999; i++) begin
            @(negedge clk25);
            seen = seen | bus.err;
        end
        chk("tmo.early", 32'(seen), 32'h0);
        @(negedge clk25);
        chk("tmo.err", 32'(bus.err), 32'h1);
        @(negedge clk25);
        chk("tmo.pulse", 32'(bus.err), 32'h0);
        send(8'h25);
        chk_state("tmo.make25", 4'b1001, 2'd3, 1'b1);
        chk_event("tmo.make25", 2'd3, 1'b1);

        send(8'h1E);
        chk_state("make1E_b", 4'b1011, 2'd1, 1'b1);
        send(8'h25);
`ifdef TYPEMATIC_EN
        chk_state("repeat25", 4'b1011, 2'd3, 1'b1);
        chk_event("repeat25", 2'd3, 1'b1);
`else
        chk_state("repeat25", 4'b1011, 2'd1, 1'b0);
`endif

        send(8'h26);
        chk_state("make26_b", 4'b1111, 2'd2, 1'b1);
        send(8'hF0);
        #3 reset = 1'b1;
        #3;
        chk_state("midreset", 4'b0000, 2'd0, 1'b0);
        chk_event("midreset", 2'd0, 1'b0);
        chk("midreset.err", 32'(bus.err), 32'h0);
        repeat (2) @(negedge clk25);
        reset = 1'b0;
        @(negedge clk25);
        send(8'h26);
        chk_state("postreset26", 4'b0100, 2'd2, 1'b1);
        chk_event("postreset26", 2'd2, 1'b1);

        // Byte lands in the very cycle the timeout would fire.
        send(8'hF0);
        repeat (24999) @(negedge clk25);
        send(8'h26);
        chk_state("coincide", 4'b0000, 2'd2, 1'b1);
        chk_event("coincide", 2'd2, 1'b0);
        chk("coincide.err", 32'(bus.err), 32'h0);
        @(negedge clk25);
        chk("coincide.err2", 32'(bus.err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
